// File: rtl/half_add_structural_pkg.sv
// Shared constants for the half_add_structural slice.
// Holds the default lane count used by the top level.
package half_add_structural_pkg;

  localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/half_add_structural_cell.sv
// One-bit structural half adder built from one xor and one and gate.
// Ports: a, b in; sum = a^b, carry = a&b out.
module half_add_structural_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  xor u_xor (sum, a, b);
  and u_and (carry, a, b);

endmodule

// File: rtl/half_add_structural.sv
// WIDTH independent half-adder lanes with combinational and registered outputs.
// Ports: clk, rst (sync, active-high), a, b in; sum, carry, sum_q, carry_q out.
module half_add_structural
  import half_add_structural_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_add_structural_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum[i]),
      .carry (carry[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      sum_q   <= sum;
      carry_q <= carry;
    end
  end

endmodule

// File: tb/tb_half_add_structural.sv
// Directed bench for half_add_structural at WIDTH 1, 4 and 8.
// Each task drives one scenario and checks outputs inline.
module tb_half_add_structural;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       a1, b1, s1, c1, sq1, cq1;
  logic [3:0] a4, b4, s4, c4, sq4, cq4;
  logic [7:0] a8, b8, s8, c8, sq8, cq8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  half_add_structural #(.WIDTH(1)) d1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1),
    .sum(s1), .carry(c1), .sum_q(sq1), .carry_q(cq1)
  );

  half_add_structural #(.WIDTH(4)) d4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4),
    .sum(s4), .carry(c4), .sum_q(sq4), .carry_q(cq4)
  );

  half_add_structural #(.WIDTH(8)) d8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8),
    .sum(s8), .carry(c8), .sum_q(sq8), .carry_q(cq8)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1;
    a4 = 4'hf; b4 = 4'hf;
    a8 = 8'hff; b8 = 8'hff;
    @(posedge clk); #1;
    tests++;
    if ({sq1, cq1} !== 2'b00) begin
      fails++;
      $display("FAIL reset_w1 got sq=%b cq=%b want 0 0", sq1, cq1);
    end
    tests++;
    if ({sq4, cq4} !== 8'h00) begin
      fails++;
      $display("FAIL reset_w4 got sq=%b cq=%b want 0 0", sq4, cq4);
    end
    tests++;
    if ({sq8, cq8} !== 16'h0000) begin
      fails++;
      $display("FAIL reset_w8 got sq=%h cq=%h want 0 0", sq8, cq8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_comb();
    logic [1:0] av [4];
    logic [1:0] ex [4];
    av = '{2'b00, 2'b01, 2'b10, 2'b11};
    ex = '{2'b00, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = av[i][1];
      b1 = av[i][0];
      #1;
      tests++;
      if ({s1, c1} !== ex[i]) begin
        fails++;
        $display("FAIL comb_%0d got s=%b c=%b want %b", i, s1, c1, ex[i]);
      end
      #999;
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0;
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1;
    #1;
    tests++;
    if ({sq1, cq1} !== 2'b00) begin
      fails++;
      $display("FAIL reg_early got sq=%b cq=%b want 0 0", sq1, cq1);
    end
    @(posedge clk); #1;
    tests++;
    if ({sq1, cq1} !== 2'b01) begin
      fails++;
      $display("FAIL reg_1cyc got sq=%b cq=%b want 0 1", sq1, cq1);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({sq1, cq1, c1} !== 3'b001) begin
      fails++;
      $display("FAIL rst_mid got sq=%b cq=%b c=%b want 0 0 1", sq1, cq1, c1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({sq1, cq1} !== 2'b01) begin
      fails++;
      $display("FAIL rst_release got sq=%b cq=%b want 0 1", sq1, cq1);
    end
  endtask

  task automatic test_sync_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({sq1, cq1} !== 2'b01) begin
      fails++;
      $display("FAIL sync_pulse got sq=%b cq=%b want 0 1", sq1, cq1);
    end
    @(posedge clk); #1;
    tests++;
    if ({sq1, cq1} !== 2'b01) begin
      fails++;
      $display("FAIL sync_after got sq=%b cq=%b want 0 1", sq1, cq1);
    end
  endtask

  task automatic test_width4();
    @(negedge clk);
    a4 = 4'b1010;
    b4 = 4'b0110;
    #1;
    tests++;
    if ({s4, c4} !== {4'b1100, 4'b0010}) begin
      fails++;
      $display("FAIL w4_comb got s=%b c=%b want 1100 0010", s4, c4);
    end
    @(posedge clk); #1;
    tests++;
    if ({sq4, cq4} !== {4'b1100, 4'b0010}) begin
      fails++;
      $display("FAIL w4_reg got sq=%b cq=%b want 1100 0010", sq4, cq4);
    end
  endtask

  task automatic test_random8();
    logic [7:0] es, ec;
    int bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      es = a8 ^ b8;
      ec = a8 & b8;
      #1;
      tests++;
      if (s8 !== es || c8 !== ec || (s8 & c8) !== 8'h00) begin
        fails++;
        if (bad++ < 5)
          $display("FAIL r8_comb_%0d got s=%h c=%h want %h %h",
                   i, s8, c8, es, ec);
      end
      @(posedge clk); #1;
      tests++;
      if (sq8 !== es || cq8 !== ec) begin
        fails++;
        if (bad++ < 5)
          $display("FAIL r8_reg_%0d got sq=%h cq=%h want %h %h",
                   i, sq8, cq8, es, ec);
      end
    end
  endtask

  initial begin
    a1 = 1'b0; b1 = 1'b0;
    a4 = '0; b4 = '0;
    a8 = '0; b8 = '0;
    test_reset();
    test_comb();
    test_registered();
    test_reset_mid();
    test_sync_reset();
    test_width4();
    test_random8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/half_add_structural.md
Name: half_add_structural

Overview:
- Bit-wise half adder built structurally from gate primitives: one XOR and one AND per lane.
- Provides combinational sum/carry outputs plus a registered copy of each for pipelined consumers.
- Used as a leaf arithmetic cell in combinational datapaths and as a building block for full adders and ripple adders.
- Default configuration is a single 1-bit half adder.

Parameters:
- WIDTH, 1, number of independent half-adder lanes; must be >= 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- sum  output  WIDTH  combinational lane sum, a[i] XOR b[i].
- carry  output  WIDTH  combinational lane carry, a[i] AND b[i].
- sum_q  output  WIDTH  registered sum.
- carry_q  output  WIDTH  registered carry.

Behaviour:
- The design has one clock; reset is synchronous and active-high.
- Combinational path:
  - sum[i] = a[i] ^ b[i]; carry[i] = a[i] & b[i], independently per lane.
  - No cross-lane carry propagation.
  - Zero cycle latency: the path contains no state, and clk and rst do not affect it.
  - Outputs settle within the same simulation time step as an input change.
- Truth table per lane (a,b -> sum,carry):
  - 0,0 -> 0,0
  - 0,1 -> 1,0
  - 1,0 -> 1,0
  - 1,1 -> 0,1
- Invariant: sum[i] and carry[i] are never both 1.
- Registered path:
  - On each rising clk edge with rst=0: sum_q <= sum and carry_q <= carry.
  - Latency is exactly 1 cycle.
  - The registers are updated every cycle; there is no enable.
- Reset:
  - On a rising clk edge with rst=1, sum_q and carry_q are cleared to all zeros.
  - Reset has no effect between edges, because it is synchronous.
  - Reset asserted mid-operation clears the registers at the next edge, while the combinational sum/carry keep tracking a and b.
  - On the first edge after rst deasserts, the registers capture the current inputs.
- Before the first reset, the register contents are undefined (X in simulation). Consumers must apply reset before relying on them.
- Arithmetic: each lane computes the 2-bit value {carry[i], sum[i]} = a[i] + b[i].
- X/Z on an input lane propagates only to that lane's outputs.
- Implementation:
  - The combinational path is built from gate primitive instances (xor/and), not behavioural operators.
  - A generate loop builds one cell per lane.

Decomposition:
- Package:
  - A shared package is optional; if one exists, it holds a localparam for the default lane width (1).
  - No typedefs are needed.
- Sub-module: half_add_cell, the 1-bit structural cell.
  - Inputs a, b; outputs sum, carry.
  - Contains one xor and one and primitive.
  - The top level instantiates WIDTH copies via generate.
- The output registers stay in the top-level module.

Test Plan:
- WIDTH=1, comb exhaustive, 1 us per step: apply (a,b) = (0,0), (0,1), (1,0), (1,1) in turn.
  - Required: (sum,carry) = (0,0), (1,0), (1,0), (0,1), each with no clock edge needed.
- WIDTH=1, registered: a=1, b=1 with rst low, before an edge.
  - Required: sum_q=0, carry_q=1 after exactly one rising edge, and not before it.
- Reset mid-operation: the registers hold carry_q=1; assert rst=1 for one cycle while a=1, b=1.
  - Required: sum_q=0, carry_q=0 after that edge, while carry stays 1.
  - Required: after deassert, carry_q=1 on the next edge.
- Synchronous reset check: pulse rst high and low again between clock edges.
  - Required: sum_q and carry_q are unchanged.
- WIDTH=4: a=4'b1010, b=4'b0110.
  - Required: sum=4'b1100, carry=4'b0010 combinationally, with the same values on sum_q and carry_q one cycle later.
- Random WIDTH=8, 200 cycles: random a and b each cycle.
  - Required: sum==a^b and carry==a&b every cycle; (sum&carry)==0 every cycle.
  - Required: sum_q and carry_q equal the previous cycle's sum and carry.
